instruction_fetch_queue: RTL

- Fetch stage feeding the decoder. Drives a single-outstanding-request instruction memory bus (cyc/stb/ack) from an internal PC and buffers returned words in a small FIFO.
- Each FIFO entry is a {pc, instruction} pair. The instruction is presented to decode as core_pkg::instruction_t over a valid/ready handshake.
- Redirects (branch, jump, trap) flush the queue and cancel any in-flight fetch.

---
 rtl/instruction_fetch_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: fetch stage that drives a single-outstanding cyc/stb/ack bus
// and buffers {pc, instruction} pairs in a small FIFO feeding decode.
package core_pkg;
   localparam logic [6:0] UlaRType = 7'b0110011;
   localparam logic [6:0] UlaIType = 7'b0010011;
   localparam logic [6:0] LoadType = 7'b0000011;
   localparam logic [6:0] StoreType = 7'b0100011;
   localparam logic [6:0] BranchType = 7'b1100011;
   localparam logic [6:0] JalType = 7'b1101111;
   localparam logic [6:0] JalrType = 7'b1100111;
   localparam logic [6:0] LuiType = 7'b0110111;
   localparam logic [6:0] AuipcType = 7'b0010111;
   localparam logic [6:0] SystemType = 7'b1110011;
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instruction_t;
endpackage

module instruction_fetch_queue #(
   parameter int DATA_SIZE = 64,
   parameter logic [DATA_SIZE-1:0] RESET_PC = '0,
   parameter int QUEUE_DEPTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   inst_mem_cyc,
   output logic                   inst_mem_stb,
   output logic [DATA_SIZE-1:0]   inst_mem_addr,
   input  logic                   inst_mem_ack,
   input  logic [31:0]            inst_mem_rd_dat,
   input  logic                   redirect_valid,
   input  logic [DATA_SIZE-1:0]   redirect_pc,
   output logic                   inst_valid,
   input  logic                   inst_ready,
   output core_pkg::instruction_t instruction,
   output logic [DATA_SIZE-1:0]   inst_pc
);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam logic [AW:0] DEPTH = (AW+1)'(QUEUE_DEPTH);
   localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2;
   logic [1:0] state, state_nx;
   logic [DATA_SIZE-1:0] pc;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count, count_nx;
   logic [DATA_SIZE-1:0] pc_mem [QUEUE_DEPTH];
   logic [31:0] dat_mem [QUEUE_DEPTH];
   logic push, pop;
   assign push = state == REQ && inst_mem_ack && !redirect_valid;
   assign pop = inst_valid && inst_ready;
   assign count_nx = count + (AW+1)'(push) - (AW+1)'(pop);
   // a redirect with no ack in the same cycle leaves one ack owed, which DROP absorbs
   always_comb
      state_nx = redirect_valid ? ((state == REQ || state == DROP) && !inst_mem_ack ? DROP : REQ)
               : state == IDLE ? (count < DEPTH ? REQ : IDLE)
               : state == REQ ? (!inst_mem_ack ? REQ : count_nx < DEPTH ? REQ : IDLE)
               : (inst_mem_ack ? REQ : DROP);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         pc <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            pc_mem[i] <= '0;
            dat_mem[i] <= '0;
         end
      end else begin
         state <= state_nx;
         if (redirect_valid) pc <= redirect_pc & ~DATA_SIZE'(3);
         else if (push) pc <= pc + DATA_SIZE'(4);
         if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
         end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count <= count_nx;
         end
         if (push) begin
            pc_mem[wr_ptr] <= pc;
            dat_mem[wr_ptr] <= inst_mem_rd_dat;
         end
      end
   assign inst_mem_cyc = state != IDLE;
   assign inst_mem_stb = state == REQ;
   assign inst_mem_addr = pc;
   assign inst_valid = count != '0;
   assign instruction = dat_mem[rd_ptr];
   assign inst_pc = pc_mem[rd_ptr];
endmodule
